// File: rtl/bcd_field_pkg.sv
// bcd_field_pkg: shared FSM state type, digit width and BCD legality check
// for the bcd_field_reg time-field register and its step datapath.
package bcd_field_pkg;

  localparam int DIGIT_W    = 4;
  localparam int MAX_DIGITS = 8;
  localparam int BCD_MAX_W  = DIGIT_W * MAX_DIGITS;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_LOCK    = 2'd1,
    ST_RELEASE = 2'd2
  } state_t;

  // 1 when each of the low 'digits' nibbles holds 0..9
  function automatic logic bcd_valid(
    input logic [BCD_MAX_W-1:0] value,
    input int                   digits
  );
    logic ok;
    ok = 1'b1;
    for (int i = 0; i < MAX_DIGITS; i++) begin
      if (i < digits &&
          value[DIGIT_W*i +: DIGIT_W] > 4'd9)
        ok = 1'b0;
    end
    return ok;
  endfunction

endpackage

// File: rtl/bcd_step.sv
// bcd_step: combinational BCD increment/decrement of one field, wrapping
// MAX_VAL->MIN_VAL (up) or MIN_VAL->MAX_VAL (down); ports val, up, nxt, wrap.
module bcd_step
  import bcd_field_pkg::*;
#(
  parameter int                        DIGITS  = 2,
  parameter logic [DIGIT_W*DIGITS-1:0] MIN_VAL = 'h00,
  parameter logic [DIGIT_W*DIGITS-1:0] MAX_VAL = 'h23
) (
  input  logic [DIGIT_W*DIGITS-1:0] val,
  input  logic                      up,
  output logic [DIGIT_W*DIGITS-1:0] nxt,
  output logic                      wrap
);

  logic               carry;
  logic [DIGIT_W-1:0] d;

  always_comb begin
    nxt   = val;
    wrap  = 1'b0;
    carry = 1'b1;
    d     = '0;
    if (up && val == MAX_VAL) begin
      nxt  = MIN_VAL;
      wrap = 1'b1;
    end else if (!up && val == MIN_VAL) begin
      nxt  = MAX_VAL;
      wrap = 1'b1;
    end else begin
      // ripple carry/borrow digit by digit
      for (int i = 0; i < DIGITS; i++) begin
        d = val[DIGIT_W*i +: DIGIT_W];
        if (carry) begin
          if (up) begin
            carry = (d == 4'd9);
            nxt[DIGIT_W*i +: DIGIT_W] =
              carry ? 4'd0 : d + 4'd1;
          end else begin
            carry = (d == 4'd0);
            nxt[DIGIT_W*i +: DIGIT_W] =
              carry ? 4'd9 : d - 4'd1;
          end
        end
      end
    end
  end

endmodule

// File: rtl/bcd_field_reg.sv
// bcd_field_reg: BCD time field, stepped by UP/DOWN with lockout (CLK,RST,
// UP,DOWN,Modificando,Actualizar,DATA_in -> DATA_out,WRAP_UP/DN,LOAD_ERR,BUSY).
// Optional auto-repeat while a button is held: define BCD_FIELD_REPEAT_EN.
module bcd_field_reg
  import bcd_field_pkg::*;
#(
  parameter int                        DIGITS        = 2,
  parameter logic [DIGIT_W*DIGITS-1:0] MIN_VAL       = 'h00,
  parameter logic [DIGIT_W*DIGITS-1:0] MAX_VAL       = 'h23,
  parameter logic [DIGIT_W*DIGITS-1:0] RST_VAL       = 'h00,
  parameter int                        LOCK_CYCLES   = 1048576,
  parameter int                        REPEAT_CYCLES = 262144
) (
  input  logic                      CLK,
  input  logic                      RST,
  input  logic                      UP,
  input  logic                      DOWN,
  input  logic                      Modificando,
  input  logic                      Actualizar,
  input  logic [DIGIT_W*DIGITS-1:0] DATA_in,
  output logic [DIGIT_W*DIGITS-1:0] DATA_out,
  output logic                      WRAP_UP,
  output logic                      WRAP_DN,
  output logic                      LOAD_ERR,
  output logic                      BUSY
);

  localparam int W    = DIGIT_W * DIGITS;
  localparam int CMAX = (LOCK_CYCLES > REPEAT_CYCLES) ?
                        LOCK_CYCLES : REPEAT_CYCLES;
  localparam int CW   = $clog2(CMAX + 1);
  localparam logic [W-1:0] SPAN = MAX_VAL - MIN_VAL;

  state_t        state;
  logic [CW-1:0] cnt;
  logic [CW-1:0] lim;
  logic          one_btn;
  logic          idle_step;
  logic          lock_end;
  logic          do_step;
  logic          do_load;
  logic          load_ok;
  logic [W-1:0]  din_off;
  logic [W-1:0]  step_val;
  logic          step_wrap;

`ifdef BCD_FIELD_REPEAT_EN
  logic dir;
  logic rep_len;
  logic rep_step;

  assign lim = rep_len ? CW'(REPEAT_CYCLES - 1)
                       : CW'(LOCK_CYCLES - 1);
  // same single button still held at the end of the lockout
  assign rep_step = lock_end && Modificando &&
                    one_btn && (UP == dir);
  assign do_step  = idle_step | rep_step;
`else
  assign lim     = CW'(LOCK_CYCLES - 1);
  assign do_step = idle_step;
`endif

  assign one_btn   = UP ^ DOWN;
  assign idle_step = (state == ST_IDLE) &&
                     Modificando && one_btn;
  assign lock_end  = (state == ST_LOCK) && (cnt == lim);
  assign do_load   = !Modificando && Actualizar;
  assign BUSY      = (state != ST_IDLE);

  // offset compare covers MIN..MAX with one unsigned test
  assign din_off = DATA_in - MIN_VAL;
  assign load_ok = bcd_valid(BCD_MAX_W'(DATA_in), DIGITS) &&
                   (din_off <= SPAN);

  bcd_step #(
    .DIGITS  (DIGITS),
    .MIN_VAL (MIN_VAL),
    .MAX_VAL (MAX_VAL)
  ) u_step (
    .val  (DATA_out),
    .up   (UP),
    .nxt  (step_val),
    .wrap (step_wrap)
  );

  always_ff @(posedge CLK) begin
    if (RST) begin
      state    <= ST_IDLE;
      cnt      <= '0;
      DATA_out <= RST_VAL;
      WRAP_UP  <= 1'b0;
      WRAP_DN  <= 1'b0;
      LOAD_ERR <= 1'b0;
`ifdef BCD_FIELD_REPEAT_EN
      dir      <= 1'b0;
      rep_len  <= 1'b0;
`endif
    end else begin
      WRAP_UP <= do_step && step_wrap && UP;
      WRAP_DN <= do_step && step_wrap && !UP;
      if (do_step) begin
        DATA_out <= step_val;
      end else if (do_load) begin
        DATA_out <= load_ok ? DATA_in : MIN_VAL;
        LOAD_ERR <= !load_ok;
      end
      unique case (state)
        ST_IDLE: begin
          if (idle_step) begin
            state <= ST_LOCK;
            cnt   <= '0;
`ifdef BCD_FIELD_REPEAT_EN
            dir     <= UP;
            rep_len <= 1'b0;
`endif
          end
        end
        ST_LOCK: begin
          if (lock_end) begin
`ifdef BCD_FIELD_REPEAT_EN
            if (rep_step) begin
              cnt     <= '0;
              rep_len <= 1'b1;
            end else if (UP || DOWN) begin
              state <= ST_RELEASE;
            end else begin
              state <= ST_IDLE;
            end
`else
            state <= ST_RELEASE;
`endif
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        ST_RELEASE: begin
          if (!UP && !DOWN)
            state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_bcd_field_reg.sv
// tb_bcd_field_reg: directed and random checks of bcd_field_reg against a
// decimal-arithmetic reference model (LOCK_CYCLES=4, REPEAT_CYCLES=2).
module tb_bcd_field_reg;

  localparam int LOCK  = 4;
  localparam int REP   = 2;
  localparam int MIN_D = 0;
  localparam int MAX_D = 23;
  localparam int RST_D = 0;

  logic       CLK = 1'b0;
  logic       RST = 1'b0;
  logic       UP = 1'b0;
  logic       DOWN = 1'b0;
  logic       Modificando = 1'b0;
  logic       Actualizar = 1'b0;
  logic [7:0] DATA_in = 8'h00;
  logic [7:0] DATA_out;
  logic       WRAP_UP;
  logic       WRAP_DN;
  logic       LOAD_ERR;
  logic       BUSY;

  int n_cmp = 0;
  int n_bad = 0;

  int m_val;
  int m_lock;
  bit m_wu;
  bit m_wd;
  bit m_err;
  bit m_rel;
`ifdef BCD_FIELD_REPEAT_EN
  bit m_dir;
`endif

  bcd_field_reg #(
    .DIGITS        (2),
    .MIN_VAL       (8'h00),
    .MAX_VAL       (8'h23),
    .RST_VAL       (8'h00),
    .LOCK_CYCLES   (LOCK),
    .REPEAT_CYCLES (REP)
  ) dut (
    .CLK         (CLK),
    .RST         (RST),
    .UP          (UP),
    .DOWN        (DOWN),
    .Modificando (Modificando),
    .Actualizar  (Actualizar),
    .DATA_in     (DATA_in),
    .DATA_out    (DATA_out),
    .WRAP_UP     (WRAP_UP),
    .WRAP_DN     (WRAP_DN),
    .LOAD_ERR    (LOAD_ERR),
    .BUSY        (BUSY)
  );

  always #5 CLK = ~CLK;

  wire [11:0] obs = {DATA_out, WRAP_UP, WRAP_DN,
                     LOAD_ERR, BUSY};

  function automatic logic [7:0] to_bcd(input int v);
    return {4'(v / 10), 4'(v % 10)};
  endfunction

  function automatic logic [11:0] mvec();
    return {to_bcd(m_val), m_wu, m_wd, m_err,
            (m_lock > 0) || m_rel};
  endfunction

  task automatic m_step(input bit up);
    if (up) begin
      if (m_val == MAX_D) begin
        m_val = MIN_D;
        m_wu  = 1'b1;
      end else m_val = m_val + 1;
    end else begin
      if (m_val == MIN_D) begin
        m_val = MAX_D;
        m_wd  = 1'b1;
      end else m_val = m_val - 1;
    end
  endtask

  // reference: decimal value, lockout as clocks remaining
  task automatic m_clk();
    bit one;
    int hi;
    int lo;
    one = UP ^ DOWN;
    if (RST) begin
      m_val = RST_D;
      m_wu = 0; m_wd = 0; m_err = 0;
      m_lock = 0; m_rel = 0;
      return;
    end
    m_wu = 0; m_wd = 0;
    if (m_lock > 0) begin
      m_lock = m_lock - 1;
      if (m_lock == 0) begin
`ifdef BCD_FIELD_REPEAT_EN
        if (Modificando && one && UP == m_dir) begin
          m_step(UP);
          m_lock = REP;
        end else if (UP || DOWN) m_rel = 1;
`else
        m_rel = 1;
`endif
      end
    end else if (m_rel) begin
      if (!UP && !DOWN) m_rel = 0;
    end else if (Modificando && one) begin
      m_step(UP);
`ifdef BCD_FIELD_REPEAT_EN
      m_dir = UP;
`endif
      m_lock = LOCK;
    end
    if (!Modificando && Actualizar) begin
      hi = int'(DATA_in[7:4]);
      lo = int'(DATA_in[3:0]);
      if (hi <= 9 && lo <= 9 &&
          hi * 10 + lo >= MIN_D &&
          hi * 10 + lo <= MAX_D) begin
        m_val = hi * 10 + lo;
        m_err = 0;
      end else begin
        m_val = MIN_D;
        m_err = 1;
      end
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    m_clk();
    #1;
  endtask

  task automatic load(input logic [7:0] v);
    Modificando = 0; Actualizar = 1; DATA_in = v;
    tick();
    Actualizar = 0;
  endtask

  task automatic drain(input int n);
    UP = 0; DOWN = 0;
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic test_reset();
    RST = 1;
    tick();
    n_cmp++;
    if (obs !== 12'h000) begin
      n_bad++;
      $display("FAIL reset: got %h want 000", obs);
    end
    RST = 0;
    tick();
    n_cmp++;
    if (obs !== mvec()) begin
      n_bad++;
      $display("FAIL reset_idle: got %h want %h",
               obs, mvec());
    end
  endtask

  task automatic test_load();
    logic [7:0] din [5];
    logic [7:0] dex [5];
    logic       eex [5];
    din = '{8'h17, 8'h1A, 8'h24, 8'h05, 8'h99};
    dex = '{8'h17, 8'h00, 8'h00, 8'h05, 8'h00};
    eex = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
    for (int i = 0; i < 5; i++) begin
      load(din[i]);
      n_cmp++;
      if (DATA_out !== dex[i] || LOAD_ERR !== eex[i] ||
          obs !== mvec()) begin
        n_bad++;
        $display("FAIL load %h: got %h/%b want %h/%b",
                 din[i], DATA_out, LOAD_ERR,
                 dex[i], eex[i]);
      end
    end
    load(8'h05);
    Modificando = 1; Actualizar = 1; DATA_in = 8'h12;
    tick();
    Actualizar = 0;
    n_cmp++;
    if (DATA_out !== 8'h05 || obs !== mvec()) begin
      n_bad++;
      $display("FAIL load_blocked: got %h want 05",
               DATA_out);
    end
  endtask

  task automatic test_single_step();
    load(8'h09);
    Modificando = 1; UP = 1;
    for (int i = 0; i < 20; i++) begin
      tick();
      n_cmp++;
      if (obs !== mvec()) begin
        n_bad++;
        $display("FAIL hold_up cyc %0d: got %h want %h",
                 i, obs, mvec());
      end
    end
`ifndef BCD_FIELD_REPEAT_EN
    n_cmp++;
    if (DATA_out !== 8'h10 || BUSY !== 1'b1) begin
      n_bad++;
      $display("FAIL single_step: got %h/%b want 10/1",
               DATA_out, BUSY);
    end
`endif
    UP = 0;
    tick();
`ifndef BCD_FIELD_REPEAT_EN
    n_cmp++;
    if (BUSY !== 1'b0) begin
      n_bad++;
      $display("FAIL release_busy: got %b want 0", BUSY);
    end
`endif
    for (int i = 0; i < 6; i++) begin
      tick();
      n_cmp++;
      if (obs !== mvec()) begin
        n_bad++;
        $display("FAIL after_rel cyc %0d: got %h want %h",
                 i, obs, mvec());
      end
    end
  endtask

  task automatic test_wrap();
    load(8'h23);
    Modificando = 1; UP = 1;
    tick();
    n_cmp++;
    if (DATA_out !== 8'h00 || WRAP_UP !== 1'b1 ||
        WRAP_DN !== 1'b0) begin
      n_bad++;
      $display("FAIL wrap_up: got %h/%b want 00/1",
               DATA_out, WRAP_UP);
    end
    UP = 0;
    tick();
    n_cmp++;
    if (WRAP_UP !== 1'b0 || obs !== mvec()) begin
      n_bad++;
      $display("FAIL wrap_up_pulse: got %b want 0",
               WRAP_UP);
    end
    drain(7);
  endtask

  task automatic test_down();
    load(8'h00);
    Modificando = 1; DOWN = 1;
    tick();
    n_cmp++;
    if (DATA_out !== 8'h23 || WRAP_DN !== 1'b1 ||
        WRAP_UP !== 1'b0) begin
      n_bad++;
      $display("FAIL wrap_dn: got %h/%b want 23/1",
               DATA_out, WRAP_DN);
    end
    drain(7);
    load(8'h10);
    Modificando = 1; DOWN = 1;
    tick();
    n_cmp++;
    if (DATA_out !== 8'h09 || WRAP_DN !== 1'b0) begin
      n_bad++;
      $display("FAIL borrow: got %h/%b want 09/0",
               DATA_out, WRAP_DN);
    end
    drain(7);
  endtask

  task automatic test_both();
    Modificando = 1; UP = 1; DOWN = 1;
    for (int i = 0; i < 3; i++) begin
      tick();
      n_cmp++;
      if (DATA_out !== 8'h09 || BUSY !== 1'b0) begin
        n_bad++;
        $display("FAIL both_btn: got %h/%b want 09/0",
                 DATA_out, BUSY);
      end
    end
    drain(2);
  endtask

  task automatic test_reset_mid_lock();
    load(8'h15);
    Modificando = 1; UP = 1;
    tick(); tick();
    RST = 1; UP = 0;
    tick();
    n_cmp++;
    if (DATA_out !== 8'h00 || BUSY !== 1'b0) begin
      n_bad++;
      $display("FAIL rst_lock: got %h/%b want 00/0",
               DATA_out, BUSY);
    end
    RST = 0; UP = 1;
    tick();
    n_cmp++;
    if (DATA_out !== 8'h01 || BUSY !== 1'b1) begin
      n_bad++;
      $display("FAIL rst_restep: got %h/%b want 01/1",
               DATA_out, BUSY);
    end
    drain(7);
  endtask

`ifdef BCD_FIELD_REPEAT_EN
  task automatic test_repeat();
    logic [7:0] ev;
    load(8'h20);
    Modificando = 1; UP = 1;
    for (int k = 0; k < 12; k++) begin
      tick();
      ev = (k < 4) ? 8'h21 : (k < 6) ? 8'h22 :
           (k < 8) ? 8'h23 : (k < 10) ? 8'h00 : 8'h01;
      n_cmp++;
      if (DATA_out !== ev || WRAP_UP !== (k == 8)) begin
        n_bad++;
        $display("FAIL repeat k%0d: got %h/%b want %h",
                 k, DATA_out, WRAP_UP, ev);
      end
    end
    drain(7);
  endtask
`endif

  task automatic test_random();
    int sel;
    for (int i = 0; i < 1500; i++) begin
      if ($urandom_range(0, 5) == 0) begin
        sel = $urandom_range(0, 3);
        UP   = (sel == 1) || (sel == 3);
        DOWN = (sel == 2) || (sel == 3);
      end
      if ($urandom_range(0, 19) == 0)
        Modificando = ~Modificando;
      Actualizar = ($urandom_range(0, 3) == 0);
      if ($urandom_range(0, 1) == 0)
        DATA_in = to_bcd($urandom_range(0, 29));
      else
        DATA_in = 8'($urandom);
      RST = ($urandom_range(0, 299) == 0);
      tick();
      n_cmp++;
      if (obs !== mvec()) begin
        n_bad++;
        $display("FAIL random cyc %0d: got %h want %h",
                 i, obs, mvec());
      end
    end
    RST = 0;
  endtask

  initial begin
    test_reset();
    test_load();
    test_single_step();
    test_wrap();
    test_down();
    test_both();
    test_reset_mid_lock();
`ifdef BCD_FIELD_REPEAT_EN
    test_repeat();
`endif
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
